// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bounded bursts.
// Optional macro FIFO_THRESH_THROTTLE_EN: hold off new grants while fifo_threshold is high.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int IW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data_in,
  input  logic [NREQ-1:0]      last,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_din,
  input  logic                 fifo_full,
  input  logic                 fifo_threshold
);

  localparam int CW = $clog2(BURST) + 1;

  // Handshake: a word moves when fifo_wr=1, i.e. the owner holds req (valid)
  // and the FIFO is not full (ready); the requester must hold its word until then.
  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_owner;
  logic            r_busy;
  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;

  logic [IW-1:0]   w_sel;
  logic            w_found;
  int              w_idx;
  logic            w_start;
  logic            w_wr;
  logic            w_release;

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = IW'(w_idx);
      end
    end
  end

`ifdef FIFO_THRESH_THROTTLE_EN
  assign w_start = w_found & ~fifo_threshold;
`else
  logic w_unused_thr;
  assign w_unused_thr = fifo_threshold;
  assign w_start      = w_found;
`endif

  assign w_wr      = r_busy & req[r_owner] & ~fifo_full;
  assign w_release = r_busy & (~req[r_owner] |
                     (w_wr & (last[r_owner] | (r_cnt == CW'(BURST - 1)))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_OWN;
            r_gnt   <= NREQ'(1) << w_sel;
            r_owner <= w_sel;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_OWN: begin
          if (w_release) begin
            // Owner keeps its value so the last owner stays visible while idle.
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end else if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign busy     = r_busy;
  assign fifo_wr  = w_wr;
  assign ack      = w_wr;
  assign fifo_din = r_busy ? data_in[int'(r_owner) * DW +: DW] : '0;

endmodule
